mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one instance of the team's combinational 4x4 array multiplier (array_mult_structural) between NREQ requesters.
- Each requester issues 4-bit operand pairs over a valid/ready handshake; the arbiter grants round-robin and registers the operands.
- The registered 8-bit product is returned on a single response channel, tagged with the requester id.
- Sits between requester blocks and the multiplier datapath; it is the only block that drives the multiplier's inputs.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, $clog2(NREQ), requester-id width; localparam, not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_m  input  4*NREQ  multiplicand; requester i uses bits [4i+3:4i].
- req_q  input  4*NREQ  multiplier; requester i uses bits [4i+3:4i].
- rsp_valid  output  1  product valid.
- rsp_ready  input  1  downstream accepts product.
- rsp_p  output  8  product m*q, unsigned.
- rsp_id  output  IDW  index of the requester that owns rsp_p.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rsp_valid=0, rsp_p=0, rsp_id=0, busy=0, req_ready=0, op_m/op_q=0, last_grant=NREQ-1 (so requester 0 has first priority).
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Winner = first i with req_valid[i], searching from last_grant+1 upward, modulo NREQ.
  - req_ready[winner]=1 combinationally in the same cycle; no other req_ready bit is asserted.
  - On the clock edge: op_m, op_q <= winner's operands; op_id <= winner; last_grant <= winner; state -> CALC.
  - No valid requester: stay in IDLE; last_grant is unchanged.
- CALC:
  - op_m/op_q drive the multiplier.
  - On the clock edge: rsp_p <= product, rsp_id <= op_id, rsp_valid <= 1, state -> RESP.
- RESP:
  - rsp_valid=1; rsp_p and rsp_id are held stable.
  - rsp_ready=1: rsp_valid <= 0 and state -> IDLE on that edge.
  - rsp_ready=0: remain in RESP indefinitely.
- Latency: handshake in cycle T; rsp_valid is high from cycle T+2.
- Throughput: at most one product per 3 cycles; no back-to-back overlap.
- req_ready is 0 in CALC and RESP regardless of req_valid.
- Handshake rules:
  - A transfer occurs when req_valid[i] and req_ready[i] are both high.
  - Requesters must hold their operands stable while valid is high.
  - Dropping valid before ready is permitted; the arbiter keeps no memory of it.
- Arithmetic: unsigned 4x4 -> 8 bits; maximum 15*15=225; never overflows.
- Fairness: with all requesters continuously valid, the grant order is 0,1,...,NREQ-1,0,...
- Reset mid-operation: any in-flight product is discarded; rsp_valid drops immediately on assert.
- Product registering: rsp_p is only written in CALC, so it never changes while rsp_valid=1.
- The multiplier instance is purely combinational; no timing state lives inside it.

Decomposition:
- Shared package mult_share_pkg holds:
  - state enum (IDLE=2'd0, CALC=2'd1, RESP=2'd2);
  - OPW=4 operand width;
  - PW=8 product width.
- Sub-module rr_pick: combinational round-robin picker. Inputs: req vector, last_grant. Outputs: any_valid, winner index.
- The multiplier is instantiated once at top level, fed from op_m/op_q.

Test Plan:
- Single request: requester 0 valid, m=13, q=11 -> req_ready[0] same cycle; rsp_valid two cycles later with rsp_p=143, rsp_id=0.
- Extremes: requester 2 with m=15, q=15 -> rsp_p=225; then m=0, q=9 -> rsp_p=0, rsp_id=2.
- Contention: all 4 valid continuously, operands m=i+1, q=3, rsp_ready=1 -> ids 0,1,2,3,0 with products 3,6,9,12,3; req_ready stays one-hot.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_p/rsp_id held; req_ready=0 throughout although req_valid[1]=1; rsp_ready=1 -> return to IDLE, requester 1 granted next cycle.
- Reset mid-operation: assert rst_n=0 during CALC -> rsp_valid=0, busy=0 immediately; after release requester 0 wins first.
- Withdrawn request: req_valid[3] pulses for one cycle while the arbiter is in RESP -> no grant to 3, no response with rsp_id=3.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared types and widths for the shared-multiplier arbiter.
package mult_share_pkg;

  localparam int OPW = 4;  // operand width
  localparam int PW  = 8;  // product width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester and response bus between requester blocks and the arbiter.
interface mult_share_arbiter_if
  import mult_share_pkg::*;
#(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [OPW*NREQ-1:0] req_m;
  logic [OPW*NREQ-1:0] req_q;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [PW-1:0]       rsp_p;
  logic [IDW-1:0]      rsp_id;
  logic                busy;

  // Requester/consumer side
  modport master (
    output req_valid, req_m, req_q, rsp_ready,
    input  req_ready, rsp_valid, rsp_p, rsp_id, busy
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_m, req_q, rsp_ready,
    output req_ready, rsp_valid, rsp_p, rsp_id, busy
  );

endinterface

// File: rtl/array_mult_structural.sv
// Combinational unsigned array multiplier: sum of shifted AND partial products.
module array_mult_structural
  import mult_share_pkg::*;
(
  input  logic [OPW-1:0] a_i,
  input  logic [OPW-1:0] b_i,
  output logic [PW-1:0]  p_o
);

  logic [PW-1:0] row [OPW];

  for (genvar j = 0; j < OPW; j++) begin : g_row
    assign row[j] = PW'(a_i & {OPW{b_i[j]}}) << j;
  end

  // Accumulate the partial-product rows
  always_comb begin
    p_o = '0;
    for (int j = 0; j < OPW; j++) begin
      p_o = p_o + row[j];
    end
  end

endmodule

// File: rtl/mult_share_arbiter_rr_pick.sv
// Round-robin picker: first valid requester after last_grant, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_grant_i,
  output logic            any_valid_o,
  output logic [IDW-1:0]  winner_o
);

  // Scan from farthest to nearest so the nearest valid requester wins
  always_comb begin
    int idx;
    idx         = 0;
    any_valid_o = 1'b0;
    winner_o    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_grant_i) + k) % NREQ;
      if (req_i[idx]) begin
        any_valid_o = 1'b1;
        winner_o    = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one 4x4 multiplier among NREQ requesters with round-robin grants
// and a single tagged response channel.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NREQ = 4
) (
  input logic                clk,
  input logic                rst_n,
  mult_share_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic            any_valid;
  logic [IDW-1:0]  winner;
  logic            grant;
  logic [OPW-1:0]  win_m, win_q;
  logic [OPW-1:0]  op_m_q, op_q_q;
  logic [IDW-1:0]  op_id_q;
  logic [IDW-1:0]  last_grant_q;
  logic [PW-1:0]   prod;
  logic [PW-1:0]   rsp_p_q;
  logic [IDW-1:0]  rsp_id_q;
  logic            rsp_valid_q;
  logic [NREQ-1:0] req_ready_d;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i        (bus.req_valid),
    .last_grant_i (last_grant_q),
    .any_valid_o  (any_valid),
    .winner_o     (winner)
  );

  assign win_m = bus.req_m[int'(winner)*OPW +: OPW];
  assign win_q = bus.req_q[int'(winner)*OPW +: OPW];
  assign grant = (state_q == IDLE) && any_valid;

  array_mult_structural u_mult (
    .a_i (op_m_q),
    .b_i (op_q_q),
    .p_o (prod)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_valid) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: one-hot ready only to the current winner while idle
  always_comb begin
    req_ready_d = '0;
    if (grant) req_ready_d[winner] = 1'b1;
  end

  assign bus.req_ready = req_ready_d;
  assign bus.busy      = (state_q != IDLE);

  // Operand capture, grant pointer and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_m_q       <= '0;
      op_q_q       <= '0;
      op_id_q      <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      rsp_p_q      <= '0;
      rsp_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      if (grant) begin
        op_m_q       <= win_m;
        op_q_q       <= win_q;
        op_id_q      <= winner;
        last_grant_q <= winner;
      end
      // Product is only captured here, so it stays frozen while presented
      if (state_q == CALC) begin
        rsp_p_q     <= prod;
        rsp_id_q    <= op_id_q;
        rsp_valid_q <= 1'b1;
      end
      if (state_q == RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_p     = rsp_p_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter (NREQ=4).
module tb_mult_share_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  mult_share_arbiter_if #(.NREQ(4)) bus ();

  mult_share_arbiter #(.NREQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] m, input logic [3:0] q);
    bus.req_valid[i]     = v;
    bus.req_m[4*i +: 4]  = m;
    bus.req_q[4*i +: 4]  = q;
  endtask

  logic [7:0] exp_p [5];
  logic [1:0] exp_id [5];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_m     = '0;
    bus.req_q     = '0;
    bus.rsp_ready = 1'b0;
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_p  = '{8'd3, 8'd6, 8'd9, 8'd12, 8'd3};

    // Reset state
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_busy",      32'(bus.busy),      0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_p",     32'(bus.rsp_p),     0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Single request 13*11
    set_req(0, 1'b1, 4'd13, 4'd11);
    #1 chk("single_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    set_req(0, 1'b0, 4'd13, 4'd11);
    chk("single_busy_calc",  32'(bus.busy),      1);
    chk("single_valid_calc", 32'(bus.rsp_valid), 0);
    chk("single_ready_calc", 32'(bus.req_ready), 0);
    tick();
    chk("single_valid", 32'(bus.rsp_valid), 1);
    chk("single_p",     32'(bus.rsp_p),     143);
    chk("single_id",    32'(bus.rsp_id),    0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("single_done_valid", 32'(bus.rsp_valid), 0);
    chk("single_done_busy",  32'(bus.busy),      0);

    // Extremes on requester 2
    set_req(2, 1'b1, 4'd15, 4'd15);
    #1 chk("max_ready", 32'(bus.req_ready), 32'b0100);
    tick();
    set_req(2, 1'b0, 4'd15, 4'd15);
    tick();
    chk("max_p",  32'(bus.rsp_p),  225);
    chk("max_id", 32'(bus.rsp_id), 2);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    set_req(2, 1'b1, 4'd0, 4'd9);
    #1 chk("zero_ready", 32'(bus.req_ready), 32'b0100);
    tick();
    set_req(2, 1'b0, 4'd0, 4'd9);
    tick();
    chk("zero_p",  32'(bus.rsp_p),  0);
    chk("zero_id", 32'(bus.rsp_id), 2);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Fresh reset so requester 0 has first priority for the contention run
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Contention: all valid, m=i+1, q=3
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'(i + 1), 4'd3);
    bus.rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("rr_ready_%0d", g), 32'(bus.req_ready), 32'(1) << exp_id[g]);
      tick();
      chk($sformatf("rr_ready_calc_%0d", g), 32'(bus.req_ready), 0);
      tick();
      chk($sformatf("rr_valid_%0d", g), 32'(bus.rsp_valid), 1);
      chk($sformatf("rr_id_%0d", g),    32'(bus.rsp_id),    32'(exp_id[g]));
      chk($sformatf("rr_p_%0d", g),     32'(bus.rsp_p),     32'(exp_p[g]));
      chk($sformatf("rr_ready_resp_%0d", g), 32'(bus.req_ready), 0);
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    tick();

    // Backpressure: requester 2 computes 7*5, requester 1 waits
    set_req(2, 1'b1, 4'd7, 4'd5);
    #1 chk("bp_ready", 32'(bus.req_ready), 32'b0100);
    tick();
    set_req(2, 1'b0, 4'd7, 4'd5);
    set_req(1, 1'b1, 4'd2, 4'd9);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold_valid_%0d", c), 32'(bus.rsp_valid), 1);
      chk($sformatf("bp_hold_p_%0d", c),     32'(bus.rsp_p),     35);
      chk($sformatf("bp_hold_id_%0d", c),    32'(bus.rsp_id),    2);
      chk($sformatf("bp_hold_ready_%0d", c), 32'(bus.req_ready), 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("bp_idle_valid", 32'(bus.rsp_valid), 0);
    chk("bp_next_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    set_req(1, 1'b0, 4'd2, 4'd9);
    tick();
    chk("bp_next_p",  32'(bus.rsp_p),  18);
    chk("bp_next_id", 32'(bus.rsp_id), 1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Reset during CALC
    set_req(3, 1'b1, 4'd4, 4'd4);
    #1 chk("mid_ready", 32'(bus.req_ready), 32'b1000);
    tick();
    set_req(3, 1'b0, 4'd4, 4'd4);
    chk("mid_busy_calc", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.rsp_valid), 0);
    chk("mid_rst_busy",  32'(bus.busy),      0);
    chk("mid_rst_ready", 32'(bus.req_ready), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("mid_post_valid", 32'(bus.rsp_valid), 0);
    chk("mid_post_busy",  32'(bus.busy),      0);
    set_req(0, 1'b1, 4'd6, 4'd2);
    set_req(3, 1'b1, 4'd4, 4'd4);
    #1 chk("mid_first_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = '0;
    tick();
    chk("mid_first_p",  32'(bus.rsp_p),  12);
    chk("mid_first_id", 32'(bus.rsp_id), 0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Withdrawn request from requester 3 while in RESP
    set_req(1, 1'b1, 4'd3, 4'd3);
    #1 chk("wd_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    set_req(1, 1'b0, 4'd3, 4'd3);
    tick();
    chk("wd_p",  32'(bus.rsp_p),  9);
    chk("wd_id", 32'(bus.rsp_id), 1);
    set_req(3, 1'b1, 4'd5, 4'd5);
    #1 chk("wd_ready_resp", 32'(bus.req_ready), 0);
    tick();
    set_req(3, 1'b0, 4'd5, 4'd5);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("wd_idle_busy",  32'(bus.busy),      0);
    chk("wd_idle_ready", 32'(bus.req_ready), 0);
    tick();
    tick();
    chk("wd_after_valid", 32'(bus.rsp_valid), 0);
    chk("wd_after_busy",  32'(bus.busy),      0);
    chk("wd_after_id",    32'(bus.rsp_id),    1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
